alarm_controller: RTL and testbench

Alarm scheduler for the digital watch. It holds the user-set alarm time and compares it against the running hour/minute counters. It sequences the alarm through arm, ring and snooze, and drives the buzzer. It sits beside the mode controller, which supplies the alarm-set mode flag and pre-debounced single-cycle button pulses, and it shares the 1 Hz time base with the seconds counter.

---
 rtl/alarm_controller.sv | 148 ++++++++++++++
 tb/tb_alarm_controller.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/alarm_controller.sv
// Alarm scheduler: stores the alarm time, fires on the first cycle cur==alarm, sequences arm/ring/snooze, drives buzzer.
// Latency: one cycle from match or button pulse to outputs. No backpressure. Optional snooze via `ALARM_SNOOZE_EN.
module alarm_controller #(
    parameter int HOUR_RST   = 7,
    parameter int MIN_RST    = 0,
    parameter int RING_SEC   = 60,
    parameter int SNOOZE_SEC = 300,
    parameter int CNT_W      = 9
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       tick_1hz,
    input  logic [4:0] cur_hour,
    input  logic [5:0] cur_min,
    input  logic       sel_alarm,
    input  logic       inc_hour,
    input  logic       inc_min,
    input  logic       arm_toggle,
    input  logic       snooze,
    input  logic       stop,
    output logic [4:0] alm_hour,
    output logic [5:0] alm_min,
    output logic       armed,
    output logic       ringing,
    output logic       snoozing,
    output logic       buzzer
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ARMED   = 2'd1,
        RINGING = 2'd2
`ifdef ALARM_SNOOZE_EN
        ,
        SNOOZE  = 2'd3
`endif
    } state_t;

    localparam logic [CNT_W-1:0] RING_LD = CNT_W'(RING_SEC);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
`ifdef ALARM_SNOOZE_EN
    localparam logic [CNT_W-1:0] SNOOZE_LD = CNT_W'(SNOOZE_SEC);
`else
    logic unused_snooze;
    assign unused_snooze = snooze | (SNOOZE_SEC == 0);
`endif

    state_t           state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic             beep_phase, beep_nxt;
    logic             match, match_d, trigger;

    assign match   = (cur_hour == alm_hour) && (cur_min == alm_min);
    // Edge-detect so re-arming or leaving set mode on a standing match never fires.
    assign trigger = match && !match_d && !sel_alarm && (state == ARMED);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            alm_hour <= 5'(HOUR_RST);
            alm_min  <= 6'(MIN_RST);
            match_d  <= 1'b1;
        end else begin
            match_d <= match;
            if (sel_alarm && inc_hour)
                alm_hour <= (alm_hour == 5'd23) ? 5'd0 : alm_hour + 5'd1;
            if (sel_alarm && inc_min)
                alm_min <= (alm_min == 6'd59) ? 6'd0 : alm_min + 6'd1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            cnt        <= '0;
            beep_phase <= 1'b0;
        end else begin
            state      <= state_nxt;
            cnt        <= cnt_nxt;
            beep_phase <= beep_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        beep_nxt  = beep_phase;
        case (state)
            IDLE: begin
                if (arm_toggle)
                    state_nxt = ARMED;
            end
            ARMED: begin
                if (arm_toggle) begin
                    state_nxt = IDLE;
                end else if (trigger) begin
                    state_nxt = RINGING;
                    cnt_nxt   = RING_LD;
                    beep_nxt  = 1'b1;
                end
            end
            RINGING: begin
                if (stop || arm_toggle) begin
                    state_nxt = ARMED;
`ifdef ALARM_SNOOZE_EN
                end else if (snooze) begin
                    state_nxt = SNOOZE;
                    cnt_nxt   = SNOOZE_LD;
`endif
                end else if (tick_1hz) begin
                    if (cnt == CNT_ONE) begin
                        state_nxt = ARMED;
                    end else begin
                        cnt_nxt  = cnt - CNT_ONE;
                        beep_nxt = !beep_phase;
                    end
                end
            end
`ifdef ALARM_SNOOZE_EN
            SNOOZE: begin
                if (stop || arm_toggle) begin
                    state_nxt = ARMED;
                end else if (tick_1hz) begin
                    if (cnt == CNT_ONE) begin
                        state_nxt = RINGING;
                        cnt_nxt   = RING_LD;
                        beep_nxt  = 1'b1;
                    end else begin
                        cnt_nxt = cnt - CNT_ONE;
                    end
                end
            end
`endif
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        armed   = (state != IDLE);
        ringing = (state == RINGING);
        buzzer  = (state == RINGING) && beep_phase;
`ifdef ALARM_SNOOZE_EN
        snoozing = (state == SNOOZE);
`else
        snoozing = 1'b0;
`endif
    end

endmodule

// File: tb/tb_alarm_controller.sv
// Bench for alarm_controller: directed scenarios then random pulses, all checked against a time-rule reference model.
module tb_alarm_controller;
    localparam int HR = 7, MR = 0, RS = 4, SS = 3;
`ifdef ALARM_SNOOZE_EN
    localparam bit SNZ_EN = 1'b1;
`else
    localparam bit SNZ_EN = 1'b0;
`endif

    logic       clk = 1'b0, reset = 1'b0, tick_1hz = 1'b0;
    logic [4:0] cur_hour = 5'd7;
    logic [5:0] cur_min = 6'd0;
    logic       sel_alarm = 1'b0, inc_hour = 1'b0, inc_min = 1'b0;
    logic       arm_toggle = 1'b0, snooze = 1'b0, stop = 1'b0;
    logic [4:0] alm_hour;
    logic [5:0] alm_min;
    logic       armed, ringing, snoozing, buzzer;

    alarm_controller #(.HOUR_RST(HR), .MIN_RST(MR), .RING_SEC(RS), .SNOOZE_SEC(SS), .CNT_W(9)) dut (
        .clk(clk), .reset(reset), .tick_1hz(tick_1hz), .cur_hour(cur_hour), .cur_min(cur_min),
        .sel_alarm(sel_alarm), .inc_hour(inc_hour), .inc_min(inc_min), .arm_toggle(arm_toggle),
        .snooze(snooze), .stop(stop), .alm_hour(alm_hour), .alm_min(alm_min), .armed(armed),
        .ringing(ringing), .snoozing(snoozing), .buzzer(buzzer)
    );

    always #5 clk = ~clk;

    int vectors = 0, errors = 0;

    // Reference: alarm time as integers, activity flags, seconds left and seconds elapsed in the current ring.
    int m_ah, m_am, m_left, m_elapsed;
    bit m_on, m_ring, m_snz, m_prev;

    function automatic void model_reset();
        m_ah = HR; m_am = MR; m_left = 0; m_elapsed = 0;
        m_on = 0; m_ring = 0; m_snz = 0; m_prev = 1;
    endfunction

    function automatic void start_ring();
        m_ring = 1; m_snz = 0; m_left = RS; m_elapsed = 0;
    endfunction

    function automatic void model_step();
        bit match, fire;
        match = (int'(cur_hour) == m_ah) && (int'(cur_min) == m_am);
        fire  = match && !m_prev && !sel_alarm && m_on && !m_ring && !m_snz;
        if ((m_ring || m_snz) && stop) begin
            m_ring = 0; m_snz = 0;
        end else if (arm_toggle) begin
            if (m_ring || m_snz) begin m_ring = 0; m_snz = 0; end
            else m_on = !m_on;
        end else if (SNZ_EN && snooze && m_ring) begin
            m_ring = 0; m_snz = 1; m_left = SS;
        end else if (fire) begin
            start_ring();
        end else if (tick_1hz && m_ring) begin
            if (m_left == 1) m_ring = 0;
            else begin m_left--; m_elapsed++; end
        end else if (tick_1hz && m_snz) begin
            if (m_left == 1) start_ring();
            else m_left--;
        end
        m_prev = match;
        if (sel_alarm && inc_hour) m_ah = (m_ah + 1) % 24;
        if (sel_alarm && inc_min)  m_am = (m_am + 1) % 60;
    endfunction

    task automatic check(input string tag);
        logic [14:0] act, exp;
        act = {alm_hour, alm_min, armed, ringing, snoozing, buzzer};
        exp = {5'(m_ah), 6'(m_am), m_on, m_ring, m_snz, m_ring && (m_elapsed % 2 == 0)};
        vectors++;
        assert (act === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, act, exp);
        end
    endtask

    task automatic check_bit(input string tag, input logic act, input logic exp);
        vectors++;
        assert (act === exp) else begin
            errors++;
            $error("FAIL %s: observed %b expected %b", tag, act, exp);
        end
    endtask

    task automatic cycle(input string tag);
        model_step();
        @(posedge clk);
        #1;
        check(tag);
        tick_1hz = 0; inc_hour = 0; inc_min = 0; arm_toggle = 0; snooze = 0; stop = 0;
    endtask

    initial begin
        model_reset();
        #12;
        check("reset_state");
        @(negedge clk) reset = 1'b1;

        // Armed while cur already equals the alarm time: must not fire.
        arm_toggle = 1; cycle("arm");
        repeat (3) cycle("armed_idle");
        check_bit("no_fire_on_standing_match", ringing, 1'b0);
        check_bit("armed_after_toggle", armed, 1'b1);

        sel_alarm = 1; inc_min = 1; cycle("set_7_01");
        sel_alarm = 0; cycle("leave_set");
        cur_min = 6'd1; cycle("match_7_01");
        check_bit("ring_one_cycle_after_match", ringing, 1'b1);
        check_bit("buzzer_on_at_ring", buzzer, 1'b1);

        for (int k = 0; k < RS; k++) begin
            check_bit("buzz_pattern", buzzer, (k % 2 == 0));
            tick_1hz = 1; cycle("ring_tick");
            cycle("ring_gap");
        end
        check_bit("auto_stop_ringing", ringing, 1'b0);
        check_bit("auto_stop_still_armed", armed, 1'b1);

        // Walk alarm to 23:59, then wrap both fields in one cycle.
        cur_hour = 5'd12;
        sel_alarm = 1;
        repeat (16) begin inc_hour = 1; cycle("inc_hour"); end
        repeat (58) begin inc_min = 1; cycle("inc_min"); end
        check_bit("at_23_59", (alm_hour == 5'd23) && (alm_min == 6'd59), 1'b1);
        inc_hour = 1; inc_min = 1; cycle("wrap_both");
        check_bit("wrap_to_0_00", (alm_hour == 5'd0) && (alm_min == 6'd0), 1'b1);
        sel_alarm = 0; inc_hour = 1; inc_min = 1; cycle("edit_ignored");
        check_bit("edit_ignored_0_00", (alm_hour == 5'd0) && (alm_min == 6'd0), 1'b1);

        cur_hour = 5'd0; cur_min = 6'd0; cycle("match_0_00");
        check_bit("ring_at_0_00", ringing, 1'b1);
        snooze = 1; cycle("snooze_press");
        if (SNZ_EN) begin
            check_bit("snoozing_set", snoozing, 1'b1);
            check_bit("snooze_buzzer_off", buzzer, 1'b0);
            repeat (SS) begin tick_1hz = 1; cycle("snooze_tick"); end
            check_bit("ring_after_snooze", ringing, 1'b1);
            stop = 1; snooze = 1; cycle("stop_and_snooze");
            check_bit("stop_wins_armed", armed, 1'b1);
            check_bit("stop_wins_not_ringing", ringing, 1'b0);
        end else begin
            check_bit("snooze_ignored_ringing", ringing, 1'b1);
            check_bit("snooze_ignored_snoozing", snoozing, 1'b0);
            stop = 1; cycle("stop");
        end

        cur_min = 6'd1; cycle("leave_match");
        cur_min = 6'd0; cycle("rematch");
        check_bit("ring_before_reset", ringing, 1'b1);
        @(negedge clk) reset = 1'b0;
        #1;
        model_reset();
        check("mid_ring_reset");
        @(negedge clk) reset = 1'b1;

        for (int i = 0; i < 1500; i++) begin
            tick_1hz   = ($urandom_range(0, 3) == 0);
            arm_toggle = ($urandom_range(0, 31) == 0);
            stop       = ($urandom_range(0, 47) == 0);
            snooze     = ($urandom_range(0, 23) == 0);
            sel_alarm  = ($urandom_range(0, 15) == 0);
            inc_hour   = ($urandom_range(0, 15) == 0);
            inc_min    = ($urandom_range(0, 15) == 0);
            cur_hour   = ($urandom_range(0, 7) == 0) ? 5'($urandom_range(0, 23)) : 5'(m_ah);
            cur_min    = ($urandom_range(0, 2) == 0) ? 6'(m_am) : 6'($urandom_range(0, 59));
            cycle("random");
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
